// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: one result bit per clock, result
// returned through a valid/ack writeback port.
module muldiv_unit #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [1:0]        OP,
  input  logic [WIDTH-1:0]  REG_A,
  input  logic [WIDTH-1:0]  REG_B,
  input  logic [ADDR_W-1:0] RD_IN,
  output logic              BUSY,
  output logic              WB_VALID,
  output logic [ADDR_W-1:0] WB_RD,
  output logic [WIDTH-1:0]  WB_DATA,
  input  logic              WB_ACK
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]     count;
  logic [1:0]        op_reg;
  logic [ADDR_W-1:0] rd_reg;
  logic [WIDTH-1:0]  opnd;
  logic [WIDTH-1:0]  acc_hi;
  logic [WIDTH-1:0]  acc_lo;

  logic [WIDTH:0]    mul_sum;
  logic [WIDTH:0]    div_shift;
  logic [WIDTH+1:0]  div_diff;
  logic [WIDTH-1:0]  hi_nx;
  logic [WIDTH-1:0]  lo_nx;
  logic [WIDTH-1:0]  result_nx;
  logic              last_iter;

  assign last_iter = (count == LAST);

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    BUSY     = (state != IDLE);
    WB_VALID = (state == DONE);
    case (state)
      IDLE:    if (START)     state_nx = CALC;
      CALC:    if (last_iter) state_nx = DONE;
      DONE:    if (WB_ACK)    state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // acc_hi:acc_lo holds the running product (mul) or remainder:quotient (div);
  // opnd is the multiplicand for mul and the divisor for div.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    if (op_reg[1]) begin
      // Remainder stays below the divisor, so a non-negative difference always fits WIDTH bits.
      if (div_diff[WIDTH+1:WIDTH] == 2'b00) begin
        hi_nx = div_diff[WIDTH-1:0];
        lo_nx = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_nx = div_shift[WIDTH-1:0];
        lo_nx = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nx = mul_sum[WIDTH:1];
      lo_nx = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
    result_nx = op_reg[0] ? hi_nx : lo_nx;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count   <= '0;
      op_reg  <= '0;
      rd_reg  <= '0;
      opnd    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      WB_RD   <= '0;
      WB_DATA <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            count  <= '0;
            op_reg <= OP;
            rd_reg <= RD_IN;
            opnd   <= OP[1] ? REG_B : REG_A;
            acc_hi <= '0;
            acc_lo <= OP[1] ? REG_A : REG_B;
          end
        end
        CALC: begin
          count  <= count + 1'b1;
          acc_hi <= hi_nx;
          acc_lo <= lo_nx;
          if (last_iter) begin
            WB_DATA <= result_nx;
            WB_RD   <= rd_reg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
